systolic_ctrl: RTL and testbench

//   Sequencer for the 8x8 systolic MAC array. Accepts a job (tile count, weight/data SRAM base

---
 rtl/systolic_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for the 8x8 systolic MAC array.
// Issues weight/data SRAM reads per tile and drives the array controls one
// cycle later, so that they line up with the returning read data.
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds perf_cycles_o, a saturating
// count of busy cycles since the last accepted start.
//
// state | meaning
// IDLE  | waiting for a job request
// RUN   | cnt steps 0..TILE_CYCLES-1 per tile, reads issued while cnt<ARRAY_SIZE
// DRAIN | final array step of the last tile is in flight
// DONE  | one-cycle done pulse, then back to IDLE
module systolic_ctrl #(
  parameter int ARRAY_SIZE  = 8,
  parameter int ADDR_W      = 10,
  parameter int TILE_CYCLES = 24,
  parameter int OUT_START   = 16
) (
  input  logic              clk_i,
  input  logic              srstn_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [5:0]        num_tiles_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] d_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sram_ren_o,
  output logic [ADDR_W-1:0] sram_raddr_w_o,
  output logic [ADDR_W-1:0] sram_raddr_d_o,
  output logic              alu_start_o,
  output logic [8:0]        cycle_num_o,
  output logic [5:0]        matrix_index_o,
  output logic              out_valid_o,
  output logic [2:0]        out_row_o
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [8:0] CNT_LAST = 9'(TILE_CYCLES - 1);
  localparam logic [8:0] RD_END   = 9'(ARRAY_SIZE);
  localparam logic [8:0] OV_LO    = 9'(OUT_START);
  localparam logic [8:0] OV_HI    = 9'(OUT_START + ARRAY_SIZE);

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [5:0]        tile_q, tile_d;
  logic [5:0]        ntiles_q, ntiles_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] dbase_q, dbase_d;
  logic [ADDR_W-1:0] tile_off;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] raddr_w_q, raddr_w_d;
  logic [ADDR_W-1:0] raddr_d_q, raddr_d_d;
  logic              alu_q, alu_d;
  logic [8:0]        cyc_q, cyc_d;
  logic [5:0]        mi_q, mi_d;
  logic              ov_q, ov_d;
  logic [2:0]        row_q, row_d;

  // State register plus tile counters and latched job parameters
  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
      wbase_q  <= '0;
      dbase_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      wbase_q  <= wbase_d;
      dbase_q  <= dbase_d;
    end
  end

  // Next-state: job acceptance, tile stepping, abort handling
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    wbase_d  = wbase_q;
    dbase_d  = dbase_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          ntiles_d = num_tiles_i;
          wbase_d  = w_base_i;
          dbase_d  = d_base_i;
          cnt_d    = '0;
          tile_d   = '0;
          state_d  = (num_tiles_i != 6'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if ({1'b0, tile_q} + 7'd1 < {1'b0, ntiles_q}) tile_d = tile_q + 6'd1;
          else state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      DRAIN:   state_d = abort_i ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: SRAM side follows the next state, array side lags one stage
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    ren_d     = (state_d == RUN) && (cnt_d < RD_END);
    tile_off  = ADDR_W'(tile_d) * ADDR_W'(ARRAY_SIZE);
    raddr_w_d = '0;
    raddr_d_d = '0;
    if (ren_d) begin
      raddr_w_d = wbase_d + tile_off + ADDR_W'(cnt_d);
      raddr_d_d = dbase_d + tile_off + ADDR_W'(cnt_d);
    end
    alu_d = (state_q == RUN) && (state_d != IDLE);
    cyc_d = alu_d ? cnt_q : '0;
    mi_d  = alu_d ? tile_q : '0;
    ov_d  = alu_d && (cnt_q >= OV_LO) && (cnt_q < OV_HI);
    row_d = ov_d ? 3'(cnt_q - OV_LO) : '0;
  end

  // Registered outputs, cleared on reset
  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ren_q     <= 1'b0;
      raddr_w_q <= '0;
      raddr_d_q <= '0;
      alu_q     <= 1'b0;
      cyc_q     <= '0;
      mi_q      <= '0;
      ov_q      <= 1'b0;
      row_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      ren_q     <= ren_d;
      raddr_w_q <= raddr_w_d;
      raddr_d_q <= raddr_d_d;
      alu_q     <= alu_d;
      cyc_q     <= cyc_d;
      mi_q      <= mi_d;
      ov_q      <= ov_d;
      row_q     <= row_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign sram_ren_o     = ren_q;
  assign sram_raddr_w_o = raddr_w_q;
  assign sram_raddr_d_o = raddr_d_q;
  assign alu_start_o    = alu_q;
  assign cycle_num_o    = cyc_q;
  assign matrix_index_o = mi_q;
  assign out_valid_o    = ov_q;
  assign out_row_o      = row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q;
  logic        accept;

  assign accept = (state_q == IDLE) && start_i && !abort_i;

  // Busy-cycle counter: restarts on each accepted job, saturates, holds in IDLE
  always_ff @(posedge clk_i) begin
    if (!srstn_i)                     perf_q <= '0;
    else if (accept)                  perf_q <= '0;
    else if (busy_q && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles_o = perf_q;
`else
  // Build without the busy-cycle counter: no extra port or state.
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: job-level vector table, hand-written corner
// sequences and random traffic, all checked every cycle against a job-timeline
// reference model.
`timescale 1ns/1ps
module tb_systolic_ctrl;
  localparam int T = 24;

  logic       clk = 1'b0;
  logic       srstn, start, abort;
  logic [5:0] num_tiles;
  logic [9:0] w_base, d_base;
  logic       busy, done, sram_ren, alu_start, out_valid;
  logic [9:0] sram_raddr_w, sram_raddr_d;
  logic [8:0] cycle_num;
  logic [5:0] matrix_index;
  logic [2:0] out_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  systolic_ctrl dut (
    .clk_i          (clk),
    .srstn_i        (srstn),
    .start_i        (start),
    .abort_i        (abort),
    .num_tiles_i    (num_tiles),
    .w_base_i       (w_base),
    .d_base_i       (d_base),
    .busy_o         (busy),
    .done_o         (done),
    .sram_ren_o     (sram_ren),
    .sram_raddr_w_o (sram_raddr_w),
    .sram_raddr_d_o (sram_raddr_d),
    .alu_start_o    (alu_start),
    .cycle_num_o    (cycle_num),
    .matrix_index_o (matrix_index),
    .out_valid_o    (out_valid),
    .out_row_o      (out_row)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_cycles_o  (perf_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cur = 0;

  // Reference model: one job described by start cycle, tile count, bases and
  // last live cycle; expected outputs derived arithmetically from offsets.
  bit     m_have = 1'b0;
  int     m_s, m_end, m_n, m_wb, m_db;
  longint m_perf = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ren;
    logic [9:0] aw;
    logic [9:0] ad;
    logic       alu;
    logic [8:0] cn;
    logic [5:0] mi;
    logic       ov;
    logic [2:0] row;
  } outs_t;

  typedef struct {
    logic [5:0] nt;
    logic [9:0] wb;
    logic [9:0] db;
    int         lat;
    int         n_ren;
    int         n_alu;
    int         n_ov;
    logic [9:0] first_w;
    logic [9:0] last_w;
    logic [9:0] last_d;
  } vec_t;

  vec_t vecs[6];

  function automatic bit live_at(int t);
    return m_have && (t > m_s) && (t <= m_end);
  endfunction

  function automatic outs_t model_out(int t);
    outs_t o;
    int k, tot, st;
    o = '0;
    if (!live_at(t)) return o;
    k = t - m_s;
    o.busy = 1'b1;
    if (m_n == 0) begin
      o.done = (k == 1);
      return o;
    end
    tot = m_n * T;
    o.done = (k == tot + 2);
    if (k <= tot) begin
      st = k - 1;
      if (st % T < 8) begin
        o.ren = 1'b1;
        o.aw  = 10'((m_wb + (st / T) * 8 + st % T) % 1024);
        o.ad  = 10'((m_db + (st / T) * 8 + st % T) % 1024);
      end
    end
    if (k >= 2 && k <= tot + 1) begin
      st = k - 2;
      o.alu = 1'b1;
      o.cn  = 9'(st % T);
      o.mi  = 6'(st / T);
      if (st % T >= 16 && st % T < 24) begin
        o.ov  = 1'b1;
        o.row = 3'(st % T - 16);
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cur, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic rs, input logic st, input logic ab,
                       input logic [5:0] nt, input logic [9:0] wb, input logic [9:0] db);
    bit    live;
    outs_t e;
    srstn = rs; start = st; abort = ab;
    num_tiles = nt; w_base = wb; d_base = db;
    live = live_at(cur);
    if (!rs) begin
      m_have = 1'b0;
      m_perf = 0;
    end else begin
      if (live && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (ab && live) begin
        m_end = cur;
      end else if (!live && st && !ab) begin
        m_have = 1'b1;
        m_s = cur; m_n = int'(nt); m_wb = int'(wb); m_db = int'(db);
        m_end = cur + ((nt == 0) ? 1 : int'(nt) * T + 2);
        m_perf = 0;
      end
    end
    @(posedge clk);
    cur++;
    @(negedge clk);
    e = model_out(cur);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("sram_ren", 32'(sram_ren), 32'(e.ren));
    chk("raddr_w", 32'(sram_raddr_w), 32'(e.aw));
    chk("raddr_d", 32'(sram_raddr_d), 32'(e.ad));
    chk("alu_start", 32'(alu_start), 32'(e.alu));
    chk("cycle_num", 32'(cycle_num), 32'(e.cn));
    chk("matrix_index", 32'(matrix_index), 32'(e.mi));
    chk("out_valid", 32'(out_valid), 32'(e.ov));
    chk("out_row", 32'(out_row), 32'(e.row));
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 32'(m_perf));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0);
  endtask

  // Wait (bounded) for done; returns cycles since start cycle s, -1 on timeout.
  task automatic wait_done(input int s, output int lat);
    lat = -1;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        lat = cur - s;
        break;
      end
      idle(1);
    end
  endtask

  initial begin
    vec_t v;
    int   s, lat, nren, nalu, nov, nd;
    logic [9:0] fw, lw, ld;

    vecs[0] = '{6'd1,  10'h100, 10'h200, 26,   8,   24,   8,   10'h100, 10'h107, 10'h207};
    vecs[1] = '{6'd3,  10'h040, 10'h080, 74,   24,  72,   24,  10'h040, 10'h057, 10'h097};
    vecs[2] = '{6'd0,  10'h123, 10'h321, 1,    0,   0,    0,   10'h000, 10'h000, 10'h000};
    vecs[3] = '{6'd1,  10'h3FC, 10'h3FE, 26,   8,   24,   8,   10'h3FC, 10'h003, 10'h005};
    vecs[4] = '{6'd2,  10'h3F8, 10'h001, 50,   16,  48,   16,  10'h3F8, 10'h007, 10'h010};
    vecs[5] = '{6'd63, 10'h000, 10'h000, 1514, 504, 1512, 504, 10'h000, 10'h1F7, 10'h1F7};

    // Reset held two cycles with start asserted
    cycle(1'b0, 1'b1, 1'b0, 6'd1, 10'h100, 10'h200);
    cycle(1'b0, 1'b1, 1'b0, 6'd1, 10'h100, 10'h200);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ren", 32'(sram_ren), 32'd0);
    idle(2);

    // Job-level vector table
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      s = cur;
      cycle(1'b1, 1'b1, 1'b0, v.nt, v.wb, v.db);
      lat = -1; nren = 0; nalu = 0; nov = 0;
      fw = '0; lw = '0; ld = '0;
      for (int c = 0; c < 3000; c++) begin
        if (sram_ren) begin
          if (nren == 0) fw = sram_raddr_w;
          lw = sram_raddr_w;
          ld = sram_raddr_d;
          nren++;
        end
        if (alu_start) nalu++;
        if (out_valid) nov++;
        if (done) begin
          lat = cur - s;
          break;
        end
        idle(1);
      end
      chk($sformatf("vec%0d_done_latency", i), 32'(lat), 32'(v.lat));
      chk($sformatf("vec%0d_ren_count", i), 32'(nren), 32'(v.n_ren));
      chk($sformatf("vec%0d_alu_count", i), 32'(nalu), 32'(v.n_alu));
      chk($sformatf("vec%0d_valid_count", i), 32'(nov), 32'(v.n_ov));
      chk($sformatf("vec%0d_first_w", i), 32'(fw), 32'(v.first_w));
      chk($sformatf("vec%0d_last_w", i), 32'(lw), 32'(v.last_w));
      chk($sformatf("vec%0d_last_d", i), 32'(ld), 32'(v.last_d));
      idle(1);
      chk($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
      chk($sformatf("vec%0d_perf", i), perf_cycles, 32'(v.lat));
`endif
      idle(2);
    end

    // Abort during tile 1 of 3, then a fresh job
    cycle(1'b1, 1'b1, 1'b0, 6'd3, 10'h010, 10'h020);
    idle(30);
    chk("abort_pre_tile", 32'(matrix_index), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 6'd0, 10'd0, 10'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_alu", 32'(alu_start), 32'd0);
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      idle(1);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    s = cur;
    cycle(1'b1, 1'b1, 1'b0, 6'd1, 10'h010, 10'h020);
    idle(1);
    chk("restart_addr", 32'(sram_raddr_w), 32'h011);
    wait_done(s, lat);
    chk("restart_latency", 32'(lat), 32'd26);
    idle(2);

    // Start pulsed mid-job with different parameters is ignored
    s = cur;
    cycle(1'b1, 1'b1, 1'b0, 6'd1, 10'h000, 10'h000);
    idle(9);
    cycle(1'b1, 1'b1, 1'b0, 6'd3, 10'h2AA, 10'h155);
    wait_done(s, lat);
    chk("midstart_latency", 32'(lat), 32'd26);
    idle(2);

    // Abort in IDLE blocks a simultaneous start
    cycle(1'b1, 1'b1, 1'b1, 6'd2, 10'h000, 10'h000);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    idle(1);

    // Reset mid-job
    cycle(1'b1, 1'b1, 1'b0, 6'd2, 10'h0F0, 10'h0F8);
    idle(12);
    cycle(1'b0, 1'b1, 1'b0, 6'd2, 10'h0F0, 10'h0F8);
    chk("midreset_busy", 32'(busy), 32'd0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 59) == 0), 6'($urandom_range(0, 3)),
            10'($urandom), 10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
